// File: rtl/ks_pipelined_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : ks_pipelined_subtractor
// Description : Pipelined WIDTH-bit Kogge-Stone subtractor. Computes
//               diff = (a - b) mod 2^WIDTH and an unsigned borrow flag by
//               evaluating a + ~b + 1 through a parallel-prefix carry
//               network with one register rank per prefix level.
//               A valid/ready handshake provides backpressure; the whole
//               pipeline advances or holds as a unit.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      operand/result width in bits (2..64)
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   pipeline can accept an operand pair this cycle
//   a          minuend
//   b          subtrahend
//   out_valid  diff/borrow valid
//   out_ready  downstream accepts the result this cycle
//   diff       (a - b) mod 2^WIDTH
//   borrow     1 when a < b (unsigned)
//   ovf        signed overflow of a - b (only with KS_SUB_OVERFLOW_EN)
// Build option
//   KS_SUB_OVERFLOW_EN  when defined, adds the registered ovf output.
// Latency
//   A pair accepted on edge 0 is presented after edge $clog2(WIDTH).
// ============================================================================
module ks_pipelined_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef KS_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  // Number of prefix levels; also the index of the output rank.
  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if ((WIDTH < 2) || (WIDTH > 64)) begin : g_bad_width
      $fatal(1, "ks_pipelined_subtractor: WIDTH=%0d outside legal range 2..64", WIDTH);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Pipeline state
  //   Ranks 0..LEVELS-1 hold prefix P/G of their level, a copy of the stage-0
  //   propagate (needed for the final sum XOR) and a valid bit.
  //   The output rank holds diff/borrow/out_valid directly.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]  p_q   [LEVELS];
  logic [WIDTH-1:0]  p_d   [LEVELS];
  logic [WIDTH-1:0]  g_q   [LEVELS];
  logic [WIDTH-1:0]  g_d   [LEVELS];
  logic [WIDTH-1:0]  p0_q  [LEVELS];
  logic [WIDTH-1:0]  p0_d  [LEVELS];
  logic [LEVELS-1:0] valid_q;
  logic [LEVELS-1:0] valid_d;

  logic             out_valid_q;
  logic             out_valid_d;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_d;
  logic             borrow_q;
  logic             borrow_d;

`ifdef KS_SUB_OVERFLOW_EN
  // Operand sign bits travel with the data for the overflow decision.
  logic [LEVELS-1:0] a_msb_q;
  logic [LEVELS-1:0] a_msb_d;
  logic [LEVELS-1:0] b_msb_q;
  logic [LEVELS-1:0] b_msb_d;
  logic              ovf_q;
  logic              ovf_d;
`endif

  // --------------------------------------------------------------------------
  // Combinational terms
  // --------------------------------------------------------------------------
  logic             advance;
  logic [WIDTH-1:0] p_stage0;
  logic [WIDTH-1:0] g_stage0;
  logic [WIDTH-1:0] carries;
  logic [WIDTH-1:0] next_diff;

  // Prefix level k is computed from rank k-1 registers.
  logic [WIDTH-1:0] lvl_p [1:LEVELS];
  logic [WIDTH-1:0] lvl_g [1:LEVELS];

  // The whole pipeline moves when the output slot is empty or being drained.
  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = advance;

  // Stage-0 terms of a + ~b. The +1 carry-in is folded into bit 0 so that
  // generate at bit 0 becomes G0 | P0 and no carry-in path is needed.
  assign p_stage0 = a ^ ~b;
  assign g_stage0 = (a & ~b) | {{(WIDTH-1){1'b0}}, p_stage0[0]};

  generate
    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
      localparam int DIST = 1 << (k - 1);
      for (genvar j = 0; j < WIDTH; j++) begin : g_bit
        if (j < DIST) begin : g_pass
          assign lvl_p[k][j] = p_q[k-1][j];
          assign lvl_g[k][j] = g_q[k-1][j];
        end else begin : g_merge
          assign lvl_g[k][j] = g_q[k-1][j] | (p_q[k-1][j] & g_q[k-1][j-DIST]);
          assign lvl_p[k][j] = p_q[k-1][j] & p_q[k-1][j-DIST];
        end
      end
    end
  endgenerate

  // Carry into bit j is the final group generate of bits j-1..0; bit 0 sees
  // the folded carry-in of 1.
  assign carries   = {lvl_g[LEVELS][WIDTH-2:0], 1'b1};
  assign next_diff = p0_q[LEVELS-1] ^ carries;

  // --------------------------------------------------------------------------
  // Next-state logic: hold everything by default, shift one rank on advance.
  // --------------------------------------------------------------------------
  always_comb begin
    p_d         = p_q;
    g_d         = g_q;
    p0_d        = p0_q;
    valid_d     = valid_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    borrow_d    = borrow_q;
`ifdef KS_SUB_OVERFLOW_EN
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    ovf_d       = ovf_q;
`endif

    if (advance) begin
      // Rank 0: a bubble enters whenever no operand pair is offered.
      valid_d[0] = in_valid;
      p_d[0]     = p_stage0;
      g_d[0]     = g_stage0;
      p0_d[0]    = p_stage0;
`ifdef KS_SUB_OVERFLOW_EN
      a_msb_d[0] = a[WIDTH-1];
      b_msb_d[0] = b[WIDTH-1];
`endif

      // Intermediate ranks capture their prefix level.
      for (int k = 1; k < LEVELS; k++) begin
        valid_d[k] = valid_q[k-1];
        p_d[k]     = lvl_p[k];
        g_d[k]     = lvl_g[k];
        p0_d[k]    = p0_q[k-1];
`ifdef KS_SUB_OVERFLOW_EN
        a_msb_d[k] = a_msb_q[k-1];
        b_msb_d[k] = b_msb_q[k-1];
`endif
      end

      // Output rank: last prefix level and sum XOR land directly in flops.
      out_valid_d = valid_q[LEVELS-1];
      diff_d      = next_diff;
      borrow_d    = ~lvl_g[LEVELS][WIDTH-1];
`ifdef KS_SUB_OVERFLOW_EN
      // Signed overflow: operand signs differ and result sign differs from a.
      ovf_d       = (a_msb_q[LEVELS-1] ^ b_msb_q[LEVELS-1]) &
                    (next_diff[WIDTH-1] ^ a_msb_q[LEVELS-1]);
`endif
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LEVELS; k++) begin
        p_q[k]  <= '0;
        g_q[k]  <= '0;
        p0_q[k] <= '0;
      end
      valid_q     <= '0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
`ifdef KS_SUB_OVERFLOW_EN
      a_msb_q     <= '0;
      b_msb_q     <= '0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      p_q         <= p_d;
      g_q         <= g_d;
      p0_q        <= p0_d;
      valid_q     <= valid_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
`ifdef KS_SUB_OVERFLOW_EN
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  // Outputs come straight from the output rank.
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
`ifdef KS_SUB_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ks_pipelined_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_ks_pipelined_subtractor
// Description : Directed self-checking bench for ks_pipelined_subtractor.
//               An 8-bit instance (3 prefix levels) covers the arithmetic
//               corner cases; a 16-bit instance (4 levels) covers
//               backpressure, bubbles and asynchronous reset.
//               Honours KS_SUB_OVERFLOW_EN for the ovf output.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ks_pipelined_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // 8-bit instance
  logic       iv8 = 1'b0;
  logic       ir8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       ov8;
  logic       or8 = 1'b1;
  logic [7:0] d8;
  logic       bw8;
`ifdef KS_SUB_OVERFLOW_EN
  logic       ovf8;
`endif

  // 16-bit instance
  logic        iv16 = 1'b0;
  logic        ir16;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        ov16;
  logic        or16 = 1'b1;
  logic [15:0] d16;
  logic        bw16;
`ifdef KS_SUB_OVERFLOW_EN
  logic        ovf16;
`endif

  int passed = 0;
  int total  = 0;
  int failed = 0;

  ks_pipelined_subtractor #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a         (a8),
    .b         (b8),
    .out_valid (ov8),
    .out_ready (or8),
    .diff      (d8),
    .borrow    (bw8)
`ifdef KS_SUB_OVERFLOW_EN
    ,
    .ovf       (ovf8)
`endif
  );

  ks_pipelined_subtractor #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .a         (a16),
    .b         (b16),
    .out_valid (ov16),
    .out_ready (or16),
    .diff      (d16),
    .borrow    (bw16)
`ifdef KS_SUB_OVERFLOW_EN
    ,
    .ovf       (ovf16)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated operation on the 8-bit instance (latency 3 edges).
  task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                     input logic [7:0] exp_d, input logic exp_b, input logic exp_o);
    a8  = ta;
    b8  = tb;
    iv8 = 1'b1;
    step();              // accepting edge
    iv8 = 1'b0;
    step();
    step();
    chk({tag, "_early_valid"}, {63'd0, ov8}, 64'd0);
    step();
    chk({tag, "_valid"},  {63'd0, ov8}, 64'd1);
    chk({tag, "_diff"},   {56'd0, d8},  {56'd0, exp_d});
    chk({tag, "_borrow"}, {63'd0, bw8}, {63'd0, exp_b});
`ifdef KS_SUB_OVERFLOW_EN
    chk({tag, "_ovf"},    {63'd0, ovf8}, {63'd0, exp_o});
`else
    if (exp_o !== exp_o) $display("unreachable");
`endif
  endtask

  initial begin
    // ---------------- reset state ----------------
    step();
    step();
    chk("rst_out_valid8", {63'd0, ov8}, 64'd0);
    chk("rst_diff8",      {56'd0, d8},  64'd0);
    chk("rst_borrow8",    {63'd0, bw8}, 64'd0);
    chk("rst_in_ready8",  {63'd0, ir8}, 64'd1);
    chk("rst_out_valid16", {63'd0, ov16}, 64'd0);
    chk("rst_in_ready16",  {63'd0, ir16}, 64'd1);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready8", {63'd0, ir8}, 64'd1);

    // ---------------- 8-bit arithmetic ----------------
    op8("sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    op8("sub_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    op8("sub_00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    op8("sub_00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    op8("sub_a5_a5", 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0);
    op8("sub_ff_00", 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
    op8("sub_00_ff", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
    op8("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    op8("sub_7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    op8("sub_3c_17", 8'h3C, 8'h17, 8'h25, 1'b0, 1'b0);

    // ---------------- 16-bit backpressure ----------------
    a16 = 16'h1000; b16 = 16'h0001; iv16 = 1'b1;
    step();                                   // e0
    a16 = 16'hFFFF; b16 = 16'hFFFF;
    step();                                   // e1
    a16 = 16'h0000; b16 = 16'h8000;
    step();                                   // e2
    a16 = 16'h1234; b16 = 16'h0234;
    step();                                   // e3
    iv16 = 1'b0;
    chk("bp_not_yet_valid", {63'd0, ov16}, 64'd0);
    step();                                   // e4: first result
    chk("bp_r1_valid",  {63'd0, ov16}, 64'd1);
    chk("bp_r1_diff",   {48'd0, d16},  64'h0FFF);
    chk("bp_r1_borrow", {63'd0, bw16}, 64'd0);
    or16 = 1'b0;
    #1;
    chk("bp_in_ready_low", {63'd0, ir16}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bp_stall_valid",    {63'd0, ov16}, 64'd1);
      chk("bp_stall_diff",     {48'd0, d16},  64'h0FFF);
      chk("bp_stall_in_ready", {63'd0, ir16}, 64'd0);
    end
    or16 = 1'b1;
    step();
    chk("bp_r2_valid",  {63'd0, ov16}, 64'd1);
    chk("bp_r2_diff",   {48'd0, d16},  64'h0000);
    chk("bp_r2_borrow", {63'd0, bw16}, 64'd0);
    step();
    chk("bp_r3_valid",  {63'd0, ov16}, 64'd1);
    chk("bp_r3_diff",   {48'd0, d16},  64'h8000);
    chk("bp_r3_borrow", {63'd0, bw16}, 64'd1);
    step();
    chk("bp_r4_valid",  {63'd0, ov16}, 64'd1);
    chk("bp_r4_diff",   {48'd0, d16},  64'h1000);
    chk("bp_r4_borrow", {63'd0, bw16}, 64'd0);
    step();
    chk("bp_drained", {63'd0, ov16}, 64'd0);

    // ---------------- 16-bit bubble stream ----------------
    a16 = 16'h0010; b16 = 16'h0001; iv16 = 1'b1;
    step();                                   // e0: A accepted
    iv16 = 1'b0;
    step();                                   // e1: bubble
    a16 = 16'h0001; b16 = 16'h0002; iv16 = 1'b1;
    step();                                   // e2: B accepted
    iv16 = 1'b0;
    step();                                   // e3
    chk("bub_e3_valid", {63'd0, ov16}, 64'd0);
    step();                                   // e4: A
    chk("bub_a_valid",  {63'd0, ov16}, 64'd1);
    chk("bub_a_diff",   {48'd0, d16},  64'h000F);
    chk("bub_a_borrow", {63'd0, bw16}, 64'd0);
    step();                                   // e5: bubble
    chk("bub_gap_valid", {63'd0, ov16}, 64'd0);
    step();                                   // e6: B
    chk("bub_b_valid",  {63'd0, ov16}, 64'd1);
    chk("bub_b_diff",   {48'd0, d16},  64'hFFFF);
    chk("bub_b_borrow", {63'd0, bw16}, 64'd1);
    step();
    chk("bub_end_valid", {63'd0, ov16}, 64'd0);

    // ---------------- reset mid-operation ----------------
    a16 = 16'h0003; b16 = 16'h0001; iv16 = 1'b1;
    step();
    a16 = 16'h0007; b16 = 16'h0002;
    step();
    a16 = 16'h0100; b16 = 16'h0001;
    step();
    iv16 = 1'b0;
    #2;
    rst_n = 1'b0;                              // between edges
    #1;
    chk("arst_valid",    {63'd0, ov16}, 64'd0);
    chk("arst_diff",     {48'd0, d16},  64'd0);
    chk("arst_borrow",   {63'd0, bw16}, 64'd0);
    chk("arst_in_ready", {63'd0, ir16}, 64'd1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("arst_no_stale", {63'd0, ov16}, 64'd0);
    end
    a16 = 16'h0009; b16 = 16'h0004; iv16 = 1'b1;
    step();
    iv16 = 1'b0;
    step();
    step();
    step();
    chk("post_rst_early", {63'd0, ov16}, 64'd0);
    step();
    chk("post_rst_valid",  {63'd0, ov16}, 64'd1);
    chk("post_rst_diff",   {48'd0, d16},  64'h0005);
    chk("post_rst_borrow", {63'd0, bw16}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
